// File: rtl/frame_capture.sv
// Double-buffered frame store: pixels are written by (x, y) into one bank while the
// other bank is scanned out in raster order; banks swap on frame_end.
module frame_capture #(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int B_WIDTH  = 3,
  parameter int B_HEIGHT = 3,
  parameter int B_VGA    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [B_WIDTH-1:0]    xin,
  input  logic [B_HEIGHT-1:0]   yin,
  input  logic [B_VGA*3-1:0]    rgbin,
  input  logic                  frame_end,
  output logic                  frame_drop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [B_WIDTH-1:0]    xout,
  output logic [B_HEIGHT-1:0]   yout,
  output logic [B_VGA*3-1:0]    rgbout,
  output logic                  out_last
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = B_VGA * 3;

  localparam logic [B_WIDTH:0]    XLIM = (B_WIDTH + 1)'(WIDTH);
  localparam logic [B_HEIGHT:0]   YLIM = (B_HEIGHT + 1)'(HEIGHT);
  localparam logic [B_WIDTH-1:0]  XMAX = B_WIDTH'(WIDTH - 1);
  localparam logic [B_HEIGHT-1:0] YMAX = B_HEIGHT'(HEIGHT - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t              state, state_n;
  logic                wr_bank, wr_bank_n;
  logic                rd_bank;
  logic                pending, pending_n;
  logic                drop_n;
  logic [B_WIDTH-1:0]  x, x_n;
  logic [B_HEIGHT-1:0] y, y_n;

  logic [PW-1:0]       mem [2][DEPTH];

  logic                pix_fire;
  logic                in_range;
  logic                scan_fire;
  logic                at_last;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;

  // The display bank is always the one not being written.
  assign rd_bank   = ~wr_bank;
  assign pix_ready = ~pending;
  assign pix_fire  = pix_valid & pix_ready;
  assign in_range  = ({1'b0, xin} < XLIM) && ({1'b0, yin} < YLIM);
  assign wr_addr   = AW'(yin) * AW'(WIDTH) + AW'(xin);
  assign rd_addr   = AW'(y) * AW'(WIDTH) + AW'(x);

  assign out_valid = (state == SCAN);
  assign scan_fire = out_valid & out_ready;
  assign at_last   = (x == XMAX) && (y == YMAX);
  assign out_last  = out_valid & at_last;
  assign xout      = x;
  assign yout      = y;
  assign rgbout    = mem[rd_bank][rd_addr];

  always_ff @(posedge clock) begin
    if (pix_fire && in_range) begin
      mem[wr_bank][wr_addr] <= rgbin;
    end
  end

  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    wr_bank_n = wr_bank;
    pending_n = pending;
    drop_n    = frame_end & pending;
    case (state)
      IDLE: begin
        if (frame_end) begin
          wr_bank_n = ~wr_bank;
          state_n   = SCAN;
          x_n       = '0;
          y_n       = '0;
        end
      end
      SCAN: begin
        // A frame_end landing on the last-pixel handshake swaps directly instead of pending.
        if (frame_end && !pending && !(scan_fire && at_last)) begin
          pending_n = 1'b1;
        end
        if (scan_fire) begin
          if (x == XMAX) begin
            x_n = '0;
            if (y == YMAX) begin
              y_n = '0;
              if (pending || frame_end) begin
                wr_bank_n = ~wr_bank;
                pending_n = 1'b0;
              end
            end else begin
              y_n = y + B_HEIGHT'(1);
            end
          end else begin
            x_n = x + B_WIDTH'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_bank    <= 1'b0;
      pending    <= 1'b0;
      frame_drop <= 1'b0;
      x          <= '0;
      y          <= '0;
    end else begin
      state      <= state_n;
      wr_bank    <= wr_bank_n;
      pending    <= pending_n;
      frame_drop <= drop_n;
      x          <= x_n;
      y          <= y_n;
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// Randomized bench for frame_capture: a frame-level reference model (linear scan
// index, two modelled banks) is compared against the DUT on every falling edge.
module tb_frame_capture;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int PW = 12;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          pix_valid;
  logic          pix_ready;
  logic [BW-1:0] xin;
  logic [BH-1:0] yin;
  logic [PW-1:0] rgbin;
  logic          frame_end;
  logic          frame_drop;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] xout;
  logic [BH-1:0] yout;
  logic [PW-1:0] rgbout;
  logic          out_last;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  frame_capture #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .B_WIDTH (BW),
    .B_HEIGHT(BH),
    .B_VGA   (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .xin       (xin),
    .yin       (yin),
    .rgbin     (rgbin),
    .frame_end (frame_end),
    .frame_drop(frame_drop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xout      (xout),
    .yout      (yout),
    .rgbout    (rgbout),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  // Reference model: the display frame is a linear pixel index; a swap flips which bank is shown.
  logic [PW-1:0] mm    [2][W*H];
  bit            known [2][W*H];
  bit            m_wb, m_scan, m_pend, m_drop;
  int unsigned   m_p;
  bit            nwb, nscan, npend;
  int unsigned   np;
  int unsigned   widx;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_wb   <= 1'b0;
      m_scan <= 1'b0;
      m_pend <= 1'b0;
      m_drop <= 1'b0;
      m_p    <= 0;
    end else begin
      nwb   = m_wb;
      nscan = m_scan;
      npend = m_pend;
      np    = m_p;
      if (pix_valid && !m_pend && int'(xin) < W && int'(yin) < H) begin
        widx = int'(yin) * W + int'(xin);
        mm[m_wb][widx]    <= rgbin;
        known[m_wb][widx] <= 1'b1;
      end
      if (!m_scan) begin
        if (frame_end) begin
          nwb   = !m_wb;
          nscan = 1'b1;
          np    = 0;
        end
      end else begin
        if (frame_end && !m_pend && !(out_ready && m_p == W*H-1)) npend = 1'b1;
        if (out_ready) begin
          if (m_p == W*H-1) begin
            np = 0;
            if (m_pend || frame_end) begin
              nwb   = !m_wb;
              npend = 1'b0;
            end
          end else begin
            np = m_p + 1;
          end
        end
      end
      m_drop <= frame_end && m_pend;
      m_wb   <= nwb;
      m_scan <= nscan;
      m_pend <= npend;
      m_p    <= np;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_scan});
      chk("pix_ready", {31'd0, pix_ready}, {31'd0, !m_pend});
      chk("frame_drop", {31'd0, frame_drop}, {31'd0, m_drop});
      chk("out_last", {31'd0, out_last}, {31'd0, m_scan && m_p == W*H-1});
      chk("xout", {28'd0, xout}, m_p % W);
      chk("yout", {28'd0, yout}, m_p / W);
      if (m_scan && known[!m_wb][m_p]) chk("rgbout", {20'd0, rgbout}, {20'd0, mm[!m_wb][m_p]});
    end
  end

  task automatic wait_p(input int unsigned target, input int unsigned limit);
    int unsigned n = 0;
    while (m_p != target && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (m_p != target) begin
      checks++;
      failures++;
      $display("FAIL wait_scan_index actual=%0d required=%0d", m_p, target);
    end
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0;
    frame_end = 1'b0;
    xin       = '0;
    yin       = '0;
    rgbin     = '0;
  endtask

  logic [PW-1:0] fb [W*H];

  initial begin
    idle_inputs();
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pix_ready", {31'd0, pix_ready}, 32'd1);
    chk("rst_frame_drop", {31'd0, frame_drop}, 32'd0);
    chk("rst_xy", {24'd0, xout, yout}, 32'd0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Frame A: rgb = y*8+x, then scan it out with out_ready held high.
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pix_valid = 1'b1;
        xin       = BW'(x);
        yin       = BH'(y);
        rgbin     = PW'(y * W + x);
        @(negedge clock);
      end
    end
    idle_inputs();
    frame_end = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < W*H; i++) begin
      chk("scan_a_rgb", {20'd0, rgbout}, i);
      chk("scan_a_last", {31'd0, out_last}, {31'd0, i == W*H-1});
      @(negedge clock);
    end

    // Frame B written during scan; frame_end at pixel (2,3); second pulse is dropped.
    for (int k = 0; k < W*H; k++) begin
      fb[k]     = PW'($urandom);
      pix_valid = 1'b1;
      xin       = BW'(k % W);
      yin       = BH'(k / W);
      rgbin     = fb[k];
      @(negedge clock);
    end
    idle_inputs();
    wait_p(3 * W + 2, 200);
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    chk("pending_ready", {31'd0, pix_ready}, 32'd0);
    repeat (3) @(negedge clock);
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    chk("drop_pulse", {31'd0, frame_drop}, 32'd1);
    @(negedge clock);
    chk("drop_clear", {31'd0, frame_drop}, 32'd0);
    wait_p(0, 200);
    chk("swap_b_rgb0", {20'd0, rgbout}, {20'd0, fb[0]});
    chk("swap_ready", {31'd0, pix_ready}, 32'd1);
    @(negedge clock);
    chk("swap_b_rgb1", {20'd0, rgbout}, {20'd0, fb[1]});

    // Out-of-range write and frame_end on the last-pixel handshake.
    wait_p(W*H-1, 200);
    chk("pre_last_ready", {31'd0, pix_ready}, 32'd1);
    frame_end = 1'b1;
    pix_valid = 1'b1;
    xin       = BW'(9);
    yin       = '0;
    rgbin     = 12'hABC;
    @(negedge clock);
    idle_inputs();
    chk("direct_swap_ready", {31'd0, pix_ready}, 32'd1);
    chk("direct_swap_rgb0", {20'd0, rgbout}, 32'd0);
    @(negedge clock);
    chk("direct_swap_rgb1", {20'd0, rgbout}, 32'd1);

    // Randomized traffic: busy and stall-heavy downstream.
    for (int i = 0; i < 3000; i++) begin
      pix_valid = 1'($urandom_range(0, 1));
      xin       = BW'($urandom_range(0, 9));
      yin       = BH'($urandom_range(0, 9));
      rgbin     = PW'($urandom);
      frame_end = ($urandom_range(0, 15) == 0);
      out_ready = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      @(negedge clock);
    end
    idle_inputs();
    out_ready = 1'b1;

    // Reset in the middle of a scan.
    wait_p(20, 200);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_ready", {31'd0, pix_ready}, 32'd1);
    chk("mid_rst_drop", {31'd0, frame_drop}, 32'd0);
    chk("mid_rst_xy", {24'd0, xout, yout}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'($urandom_range(0, 1));
      xin       = BW'($urandom_range(0, 7));
      yin       = BH'($urandom_range(0, 7));
      rgbin     = PW'($urandom);
      @(negedge clock);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    idle_inputs();
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    chk("post_rst_scan", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 200; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
